// File: rtl/pwr_seq_pkg.sv
// Shared types and defaults for the supply power sequencer.
package pwr_seq_pkg;

    // Encoding is visible on the debug state port, so values are fixed.
    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StRamp     = 3'd1,
        StDebounce = 3'd2,
        StHold     = 3'd3,
        StOn       = 3'd4,
        StBackoff  = 3'd5,
        StFault    = 3'd6
    } state_e;

    localparam int unsigned DefPgTimeout   = 64;
    localparam int unsigned DefDebounceCyc = 8;
    localparam int unsigned DefRstHold     = 16;
    localparam int unsigned DefRetryWait   = 32;
    localparam int unsigned DefMaxRetry    = 3;

    localparam int unsigned RetryW = 2;

    // Counter width for a terminal value of v-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Up-counter with synchronous clear, count enable and terminal-count compare
// against a limit that may change from cycle to cycle.
module seq_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [Width-1:0] limit_i,
    output logic             tc_o
);

    logic [Width-1:0] count_d, count_q;

    // Clear wins over increment; the count holds at the limit rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !tc_o) begin
            count_d = count_q + Width'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == limit_i);

endmodule

// File: rtl/power_sequencer.sv
// Supply power sequencer: enables the rail, debounces power-good, holds the
// downstream reset, and retries on timeout/brown-out before latching a fault.
module power_sequencer
    import pwr_seq_pkg::*;
#(
    parameter int unsigned PG_TIMEOUT   = DefPgTimeout,
    parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc,
    parameter int unsigned RST_HOLD     = DefRstHold,
    parameter int unsigned RETRY_WAIT   = DefRetryWait,
    parameter int unsigned MAX_RETRY    = DefMaxRetry
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              shutdown,
    input  logic              pg,
    output logic              en,
    output logic              rst_out_n,
    output logic              ready,
    output logic              fault,
    output logic [RetryW-1:0] retry_cnt,
    output logic [2:0]        state
);

    // One timer serves timeout, hold and backoff; debounce needs its own since
    // the timeout keeps running while pg-high samples are being counted.
    localparam int unsigned TmrW = cnt_width(max3(PG_TIMEOUT, RST_HOLD, RETRY_WAIT));
    localparam int unsigned DebW = cnt_width(DEBOUNCE_CYC);

    state_e state_d, state_q;
    logic [RetryW-1:0] retry_d, retry_q;
    logic              tmr_clr, tmr_inc, tmr_tc;
    logic              deb_clr, deb_inc, deb_tc;
    logic [TmrW-1:0]   tmr_limit;
    logic              fail;

    // Per-state terminal value for the shared timer.
    always_comb begin
        tmr_limit = TmrW'(PG_TIMEOUT - 1);
        unique case (state_q)
            StHold:    tmr_limit = TmrW'(RST_HOLD - 1);
            StBackoff: tmr_limit = TmrW'(RETRY_WAIT - 1);
            default:   tmr_limit = TmrW'(PG_TIMEOUT - 1);
        endcase
    end

    seq_timer #(
        .Width (TmrW)
    ) u_tmr (
        .clk_i   (clk),
        .rst_ni  (arst_n),
        .clr_i   (tmr_clr),
        .inc_i   (tmr_inc),
        .limit_i (tmr_limit),
        .tc_o    (tmr_tc)
    );

    seq_timer #(
        .Width (DebW)
    ) u_deb (
        .clk_i   (clk),
        .rst_ni  (arst_n),
        .clr_i   (deb_clr),
        .inc_i   (deb_inc),
        .limit_i (DebW'(DEBOUNCE_CYC - 1)),
        .tc_o    (deb_tc)
    );

    // Next-state, retry accounting and timer control; shutdown overrides everything.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        deb_clr = 1'b0;
        deb_inc = 1'b0;
        fail    = 1'b0;

        unique case (state_q)
            StOff: begin
                if (start) begin
                    state_d = StRamp;
                    tmr_clr = 1'b1;
                end
            end
            StRamp: begin
                tmr_inc = 1'b1;
                if (tmr_tc) begin
                    fail = 1'b1;            // timeout beats a pg rise on the same edge
                end else if (pg) begin
                    state_d = StDebounce;
                    deb_clr = 1'b1;
                end
            end
            StDebounce: begin
                tmr_inc = 1'b1;
                if (pg && deb_tc) begin
                    state_d = StHold;       // completed debounce beats timeout
                    tmr_clr = 1'b1;
                    tmr_inc = 1'b0;
                end else if (tmr_tc) begin
                    fail = 1'b1;
                end else if (pg) begin
                    deb_inc = 1'b1;
                end else begin
                    state_d = StRamp;       // timeout budget is not restarted
                end
            end
            StHold: begin
                if (!pg) begin
                    fail = 1'b1;
                end else if (tmr_tc) begin
                    state_d = StOn;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            StOn: begin
                if (!pg) begin
                    fail = 1'b1;
                end
            end
            StBackoff: begin
                if (tmr_tc) begin
                    state_d = StRamp;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StOff;
            end
        endcase

        if (fail) begin
            if (retry_q == RetryW'(MAX_RETRY)) begin
                state_d = StFault;
            end else begin
                retry_d = retry_q + RetryW'(1);
                state_d = StBackoff;
                tmr_clr = 1'b1;
            end
        end

        if (shutdown) begin
            state_d = StOff;
            retry_d = '0;
            tmr_clr = 1'b1;
            deb_clr = 1'b1;
        end
    end

    // State and retry registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= StOff;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
        end
    end

    // Moore output decode of the registered state.
    always_comb begin
        en        = 1'b0;
        rst_out_n = 1'b0;
        ready     = 1'b0;
        fault     = 1'b0;
        unique case (state_q)
            StRamp, StDebounce, StHold: en = 1'b1;
            StOn: begin
                en        = 1'b1;
                rst_out_n = 1'b1;
                ready     = 1'b1;
            end
            StFault: fault = 1'b1;
            default: en = 1'b0;
        endcase
    end

    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule
